// File: rtl/counter_updown_mod_pkg.sv
// Shared definitions for the up/down modulo counter family: mode encodings
// and a constant log2 helper used to size the prescaler.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/counter_updown_mod_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface counter_updown_mod_if #(
  parameter int WIDTH = 4
);

  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (output clr, load, load_val, en, up, input count, tc, wrap);
  modport slave  (input clr, load, load_val, en, up, output count, tc, wrap);

endinterface

// File: rtl/counter_updown_mod_tick.sv
// Enable prescaler: emits a one-cycle step every PRESCALE enabled cycles;
// collapses to step = en when PRESCALE == 1.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step
);

  if (PRESCALE <= 1) begin : g_bypass
    logic unused_presc;
    assign unused_presc = clk ^ rst_n ^ clr;
    assign step = en;
  end else begin : g_div
    localparam int unsigned    PW   = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q;

    assign step = en && (presc_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        presc_q <= '0;
      end else if (clr) begin
        presc_q <= '0;
      end else if (en) begin
        presc_q <= step ? '0 : presc_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with prescaled enable, sync clear/load,
// wrap or saturate at the range ends, combinational terminal count and wrap pulse.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int PRESCALE = 1,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  counter_updown_mod_if.slave  bus
);

  if (WIDTH < 1) begin : g_chk_width
    $error("counter_updown_mod: WIDTH must be >= 1");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_chk_mod
    $error("counter_updown_mod: MODULUS must be in 2..2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_chk_presc
    $error("counter_updown_mod: PRESCALE must be >= 1");
  end

  // Range limits kept one bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0] TOP  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] MODV = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             step, at_top, at_bot, at_end;
  logic [WIDTH:0]   cnt_x, load_x;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr | bus.load),
    .en    (bus.en),
    .step  (step)
  );

  assign cnt_x  = {1'b0, count_q};
  assign load_x = {1'b0, bus.load_val};
  assign at_top = (cnt_x == TOP);
  assign at_bot = (cnt_x == '0);
  assign at_end = bus.up ? at_top : at_bot;

  // sat_q remembers that the count is parked at a saturation end, so only the
  // first held step reports a saturation hit on wrap.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    if (bus.clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (bus.load) begin
      count_d = (load_x >= MODV) ? TOP[WIDTH-1:0] : bus.load_val;
      sat_d   = 1'b0;
    end else if (step) begin
      if (at_end) begin
        if (SATURATE == CNT_SAT) begin
          wrap_d = !sat_q;
          sat_d  = 1'b1;
        end else begin
          wrap_d  = 1'b1;
          count_d = bus.up ? '0 : TOP[WIDTH-1:0];
        end
      end else begin
        count_d = bus.up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        sat_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = rst_n & step & at_end;

endmodule
